mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 32x32 multicycle multiplier (OpRdy/ResRdy handshake) among NREQ requesters.
- Accepts one operand pair at a time, issues it to the multiplier, waits for the result and returns it to the owning requester.
- Sits between client datapaths and the single multiplier instance; the multiplier is driven only through this block.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width; must match the multiplier
TIMEOUT, 15, max WAIT cycles before abort (used only with MULT_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, asynchronous, active-high
req_valid  in  NREQ  per-requester operand pair valid
req_op0  in  NREQ*W  packed operand 0, requester i at [i*W +: W]
req_op1  in  NREQ*W  packed operand 1
req_ready  out  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
rsp_valid  out  NREQ  one-hot one-cycle result pulse to owner
rsp_res  out  W  result; valid while any rsp_valid bit is high
rsp_err  out  1  timeout flag, qualified by rsp_valid
mul_oprdy  out  1  to multiplier OpRdy
mul_op0  out  W  to multiplier op0
mul_op1  out  W  to multiplier op1
mul_resrdy  in  1  from multiplier ResRdy
mul_res  in  W  from multiplier res
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state=IDLE; rr pointer=NREQ-1, so requester 0 wins first. All outputs 0. Operand and owner registers cleared.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - winner = first i with req_valid[i], searching from pointer+1 modulo NREQ.
  - req_ready[winner] is combinational, asserted only in IDLE.
  - On the transfer edge: latch op0/op1, latch owner = winner, set pointer = winner, go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: mul_oprdy=1 for exactly one cycle, with mul_op0/mul_op1 driven from the latched operands. Go to WAIT.
- WAIT: on mul_resrdy=1, capture mul_res into rsp_res and go to RESP. Otherwise stay.
- RESP: rsp_valid[owner]=1 for exactly one cycle; rsp_res is held. Return to IDLE.
  - The next grant can occur in the IDLE cycle immediately after RESP.
- Latency: accept cycle a, mul_oprdy in a+1. With the standard multiplier (ResRdy 3 cycles after OpRdy), rsp_valid is in a+5.
- Throughput: one operation per 6 cycles under continuous load.
- Arithmetic: result is the multiplier's low W bits; no saturation, so overflow wraps. The block does not modify the result.
- Requester rules:
  - Hold req_valid and operands stable until accepted; deasserting before acceptance is allowed.
  - No backpressure on responses.
- rsp_valid, req_ready and mul_oprdy are each at most one-hot, and never high together with each other.
- mul_resrdy outside WAIT is ignored.
- Reset mid-operation: the in-flight operation is dropped with no rsp_valid. The multiplier shares rst.
- Requests arriving while busy wait; they see no req_ready until IDLE.

Optional Feature:
MULT_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles pass without mul_resrdy, go to RESP with rsp_err=1 and rsp_res=0.
  - A late mul_resrdy after the abort is ignored.
- Undefined: no counter, WAIT is unbounded, rsp_err tied 0.

Decomposition:
- Package mult_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default W and NREQ constants, owner index width function ($clog2(NREQ)).
- Sub-module rr_pick: combinational round-robin priority picker with inputs req vector and pointer, outputs one-hot grant, index and any.

Test Plan:
1. req0 with 3 x 5 -> req_ready[0] same cycle; mul_oprdy one cycle later, op0=3, op1=5; rsp_valid[0] at a+5 with rsp_res=15, rsp_err=0.
2. All four req_valid held continuously with distinct operands -> grants in order 0,1,2,3,0 at 6-cycle spacing; each rsp_valid[i] carries that requester's product.
3. req2 with 0xFFFFFFFF x 2 -> rsp_res=0xFFFFFFFE (wrap); 0 x 0x12345678 -> 0.
4. req1 raised during req0's WAIT -> req_ready[1] low until the IDLE cycle after rsp_valid[0]; then accepted with the operands held.
5. rst pulsed during WAIT -> all outputs 0 immediately; no rsp_valid; after release with req0 and req3 valid, req0 wins.
6. MULT_ARB_TIMEOUT_EN defined, multiplier stub never asserts ResRdy -> rsp_valid[owner] after 15 WAIT cycles with rsp_err=1, rsp_res=0; the block then accepts the next request.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mult_arb_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_W       = 32;
  localparam int unsigned DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier bus of mult_arbiter; slave = arbiter side, master = clients/multiplier side.
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_op0;
  logic [NREQ*W-1:0] req_op1;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_res;
  logic              rsp_err;
  logic              mul_oprdy;
  logic [W-1:0]      mul_op0;
  logic [W-1:0]      mul_op1;
  logic              mul_resrdy;
  logic [W-1:0]      mul_res;
  logic              busy;

  modport slave (
    input  req_valid, req_op0, req_op1, mul_resrdy, mul_res,
    output req_ready, rsp_valid, rsp_res, rsp_err, mul_oprdy, mul_op0, mul_op1, busy
  );

  modport master (
    output req_valid, req_op0, req_op1, mul_resrdy, mul_res,
    input  req_ready, rsp_valid, rsp_res, rsp_err, mul_oprdy, mul_op0, mul_op1, busy
  );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping modulo NREQ.
module mult_arbiter_rr_pick
  import mult_arb_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  // Walk ptr+1 .. ptr+NREQ so the last winner has lowest priority.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one multicycle multiplier among NREQ requesters.
// Optional WAIT abort enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  mult_arbiter_if.slave  bus
);

  localparam int unsigned IW = idx_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("mult_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [W-1:0]    op0_q, op0_d;
  logic [W-1:0]    op1_q, op1_d;
  logic [W-1:0]    res_q, res_d;
  logic            err_q, err_d;
  logic            tmo;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [W-1:0]    sel_op0, sel_op1;
  logic [NREQ-1:0] owner_oh;

  mult_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Operand pair of the current winner.
  always_comb begin
    sel_op0 = '0;
    sel_op1 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_op0 = bus.req_op0[i*W +: W];
        sel_op1 = bus.req_op1[i*W +: W];
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tmo = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= IW'(NREQ - 1);
      owner_q <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Next state and datapath captures.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ISSUE;
          ptr_d   = pick_idx;
          owner_d = pick_idx;
          op0_d   = sel_op0;
          op1_d   = sel_op1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.mul_resrdy) begin
          res_d   = bus.mul_res;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs from the state registers; req_ready is the only Mealy term.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.rsp_err       = 1'b0;
    bus.mul_oprdy     = 1'b0;
    bus.busy          = 1'b1;
    bus.mul_op0       = op0_q;
    bus.mul_op1       = op1_q;
    bus.rsp_res       = res_q;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = pick_gnt;
        bus.busy      = 1'b0;
      end
      ISSUE: bus.mul_oprdy = 1'b1;
      WAIT:  bus.busy      = 1'b1;
      RESP: begin
        bus.rsp_valid = owner_oh;
        bus.rsp_err   = err_q;
      end
      default: bus.busy = 1'b0;
    endcase
  end

endmodule
